// File: rtl/hpsfpga_button_in.sv
// hpsfpga_button_in: Avalon-MM input PIO for active-low buttons.
// Synchronise, debounce, capture edges, raise a maskable level irq.
module hpsfpga_button_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] ecap_q;
  logic [WIDTH-1:0] ecap_d;
  logic [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0] clr_w;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             wr_en;
  logic             unused_w;

  assign wr_en    = chipselect & ~write_n;
  assign unused_w = ^writedata;

  // Two-flop synchroniser, reset to released (high)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: accept a value only after it holds long enough
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CMAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state and delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '1;
      prev_q   <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edge select, bus clears, capture with set winning over clear
  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_w = stable_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_w = ~stable_q & prev_q;
    end else begin
      edge_w = stable_q ^ prev_q;
    end
    clr_w  = '0;
    mask_d = mask_q;
    if (wr_en && address == 2'd3) begin
      clr_w = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end
    ecap_d = (ecap_q & ~clr_w) | edge_w;
  end

  // Mask and edge-capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      ecap_q <= '0;
    end else begin
      mask_q <= mask_d;
      ecap_q <= ecap_d;
    end
  end

  // Zero-wait read mux, independent of chipselect
  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0:    readdata[WIDTH-1:0] = stable_q;
      2'd2:    readdata[WIDTH-1:0] = mask_q;
      2'd3:    readdata[WIDTH-1:0] = ecap_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(ecap_q & mask_q);

endmodule
